// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM stage: access-size encodings, FSM states, widths.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_HALF) begin
      bad = addr_lo[0];
    end else if (size != SIZE_BYTE) begin
      bad = (addr_lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  import mips_pkg::*;

  // Handshake: master raises dmem_req and holds addr/we/wdata/be stable until a
  // cycle where the slave drives dmem_ready=1; that cycle completes the access
  // and dmem_rdata is valid in it. dmem_ready is ignored while dmem_req=0.
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_be;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_stage_lane.sv
// Big-endian lane steering: store replication/byte enables and load extraction/extension.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata     = store_data;
    be        = 4'b1111;
    load_data = rdata;
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;

    case (size)
      SIZE_BYTE: begin
        // Lane 0 (addr_lo=0) is the most significant byte.
        case (addr_lo)
          2'd0:    byte_sel = rdata[31:24];
          2'd1:    byte_sel = rdata[23:16];
          2'd2:    byte_sel = rdata[15:8];
          default: byte_sel = rdata[7:0];
        endcase
        be        = 4'b1000 >> addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = load_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        half_sel  = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        be        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata     = {2{store_data[15:0]}};
        load_data = load_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues loads/stores on the data bus, stalls while the memory is not
// ready, and builds the MEM/WB write triple. Optional: MEM_ALIGN_CHECK_EN adds a misaligned output.
module mem_access_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write_in,
  input  logic [1:0]        access_size,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  write_register_destination_in,
  mem_access_stage_if.master dmem,
  output logic              stall,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] write_register_data,
  output logic [REG_W-1:0]  write_register_destination,
  output logic [15:0]       stall_cycles,
  output mem_state_e        state_dbg
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  mem_state_e  state_q, state_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic              mem_op;
  logic              bad_align;
  logic              op_go;
  logic              req;
  logic              stall_int;
  logic [DATA_W-1:0] lane_wdata;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_load_data;

  mem_lane_align u_lane (
    .size          (access_size),
    .addr_lo       (alu_result[1:0]),
    .load_unsigned (load_unsigned),
    .store_data    (store_data),
    .rdata         (dmem.dmem_rdata),
    .wdata         (lane_wdata),
    .be            (lane_be),
    .load_data     (lane_load_data)
  );

  always_comb begin
    mem_op = mem_read | mem_write;
`ifdef MEM_ALIGN_CHECK_EN
    bad_align = mem_op & is_misaligned(access_size, alu_result[1:0]);
`else
    bad_align = 1'b0;
`endif
    op_go = mem_op & ~bad_align;
    // In WAIT the upstream stall keeps the op inputs stable, so the request stays up.
    req       = (state_q == ST_WAIT) | op_go;
    stall_int = req & ~dmem.dmem_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_go && !dmem.dmem_ready) state_d = ST_WAIT;
      ST_WAIT: if (dmem.dmem_ready)           state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      stall_cycles_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    dmem.dmem_req   = req;
    dmem.dmem_we    = req & mem_write;
    dmem.dmem_addr  = {alu_result[DATA_W-1:2], 2'b00};
    dmem.dmem_wdata = lane_wdata;
    dmem.dmem_be    = lane_be;

    stall = stall_int;
    // A stalled cycle is a bubble into MEM/WB; a rejected misaligned op never writes back.
    reg_write_out              = reg_write_in & ~stall_int & ~bad_align;
    write_register_data        = mem_to_reg ? lane_load_data : alu_result;
    write_register_destination = write_register_destination_in;
    stall_cycles               = stall_cycles_q;
    state_dbg                  = state_q;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = bad_align;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the MIPS core: consumes the EX/MEM register outputs, performs loads and stores on a single-port data-memory bus with a ready handshake, and produces the register-write triple captured by the MEM/WB register. A two-state FSM stalls the pipeline while memory is not ready and inserts bubbles into MEM/WB. Byte and halfword accesses use big-endian lane order with sign or zero extension.

## Interface
- (no parameters; data width 32, register index width 5)
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- mem_read, mem_write  in  1  load / store request from EX/MEM (never both)
- mem_to_reg  in  1  1: writeback data = load data; 0: alu_result
- reg_write_in  in  1  instruction writes a register
- access_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- load_unsigned  in  1  zero-extend byte/half loads
- alu_result  in  32  effective address / ALU value
- store_data  in  32  rt value for stores
- write_register_destination_in  in  5  destination register
- dmem_req, dmem_we  out  1  bus request / write enable
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables, be[3] = bits 31:24
- dmem_rdata  in  32  read data, valid with dmem_ready
- dmem_ready  in  1  access completes this cycle
- stall  out  1  hold IF–EX/MEM stages this cycle
- reg_write_out  out  1  to MEM/WB
- write_register_data  out  32  to MEM/WB
- write_register_destination  out  5  to MEM/WB
- stall_cycles  out  16  saturating count of stall cycles

## Operation
- States: IDLE, WAIT. Reset: IDLE, stall_cycles=0.
- IDLE, no memory op: combinational pass-through; reg_write_out=reg_write_in, data=alu_result, stall=0, dmem_req=0.
- IDLE, memory op: dmem_req=1 same cycle. dmem_ready=1 → completes, stall=0, stay IDLE. dmem_ready=0 → stall=1, next WAIT.
- WAIT: dmem_req held 1; inputs held stable by upstream stall. dmem_ready=1 → complete, stall=0, next IDLE; else stall=1, stay.
- While stall=1, reg_write_out=0 (bubble into MEM/WB); destination/data don't-care.
- Store lanes: byte → wdata={4{b}}, be=4'b1000>>addr[1:0]; half → {2{h}}, be=addr[1]?0011:1100; word → be=1111. Stores: reg_write_out=reg_write_in (normally 0).
- Load extraction: byte at addr[1:0]=0 is rdata[31:24]; half addr[1]=0 is rdata[31:16]; extend per load_unsigned. dmem_be on loads = same pattern as stores.
- stall_cycles increments each cycle stall=1, saturates at 16'hFFFF.
- Reset during WAIT: dmem_req drops next cycle, request abandoned, no writeback.
- Outputs other than stall_cycles and FSM state are combinational; no registered reset values required beyond those.

## Timing
- Zero-wait access: result to MEM/WB in the issue cycle; no stall.
- N wait cycles: stall high N cycles, result presented in cycle N (0-based from issue), one writeback only.
- dmem_ready outside a request is ignored.
- Back-to-back memory ops: next op may issue in the cycle after completion.

## Configuration
- MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 → no dmem_req, reg_write_out=0, stall=0, extra output misaligned (1 bit) pulses high that cycle.
- Undefined: no misaligned port; low address bits ignored (half uses addr[1], word uses none), access proceeds.

## Structure
- Shared package mips_pkg: access-size encodings (SIZE_BYTE/HALF/WORD), FSM state enum, DATA_W=32, REG_W=5.
- One sub-module: mem_lane_align (combinational store lane/byte-enable generation and load extraction/extension).

## Test plan
- Word load addr 0x100, rdata 0xDEADBEEF, ready same cycle → stall 0, reg_write_out 1, data 0xDEADBEEF.
- Signed byte load addr 0x103, rdata 0x112233F0, 3 wait cycles → stall high 3 cycles, reg_write_out 0 during, then data 0xFFFFFFF0; stall_cycles=3.
- Half store 0xABCD addr 0x202 → dmem_we 1, be 0011, wdata 0xABCDABCD.
- Unsigned half load addr 0x200, rdata 0x8001FFFF → data 0x00008001.
- reset_n low during WAIT → next cycle dmem_req 0, stall 0, stall_cycles 0, no writeback.
- With MEM_ALIGN_CHECK_EN, word load addr 0x101 → misaligned 1, dmem_req 0, reg_write_out 0.
